// File: rtl/sram_sdp_pipe.sv
// Simple dual-port SRAM with a pipelined, fixed-latency read port.
//
// Port A writes words, and bea selects which bytes of each word are written.
// Port B reads words. After reset the block can sweep the whole array to zero
// before it accepts any traffic.
//
// Ports
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset (does not clear the array)
//   wea    : write enable, port A
//   bea    : byte enables, bit i gates dina[8i+7:8i]
//   addra  : write address (addresses >= DEPTH are dropped)
//   dina   : write data
//   reb    : read request, port B
//   addrb  : read address (addresses >= DEPTH read as zero)
//   doutb  : read data, holds its last value between valid strobes
//   dvalb  : one-cycle strobe, READ_LATENCY cycles after reb
//   rdy    : high while the block accepts reads and writes
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | zero sweep in progress, one word per cycle; requests ignored
// RUN   | normal operation; reads and writes accepted
module sram_sdp_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int READ_LATENCY  = 1,
  parameter     COLLISION     = "READ_FIRST",
  parameter int INIT_ON_RESET = 1,
  parameter     RAM_STYLE     = "auto"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wea,
  input  logic [DATA_WIDTH/8-1:0] bea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic                    reb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    dvalb,
  output logic                    rdy
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit                    WR_FIRST  = (COLLISION == "WRITE_FIRST");

  // Parameter sanity checks, evaluated at elaboration.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 512) begin : g_bad_width
    $error("sram_sdp_pipe: DATA_WIDTH must be a multiple of 8 in 8..512");
  end
  if (DEPTH < 2 || DEPTH > 65536) begin : g_bad_depth
    $error("sram_sdp_pipe: DEPTH must be in 2..65536");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("sram_sdp_pipe: READ_LATENCY must be in 1..4");
  end
  if (COLLISION != "READ_FIRST" && COLLISION != "WRITE_FIRST") begin : g_bad_coll
    $error("sram_sdp_pipe: COLLISION must be READ_FIRST or WRITE_FIRST");
  end
  if (RAM_STYLE != "auto" && RAM_STYLE != "block" && RAM_STYLE != "distributed" &&
      RAM_STYLE != "registers" && RAM_STYLE != "ultra") begin : g_bad_style
    $error("sram_sdp_pipe: unsupported RAM_STYLE");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  run;
  logic                  wr_go;
  logic                  rd_go;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  // rst_n gating keeps rdy low and blocks traffic while reset is held,
  // including configurations that come out of reset directly in RUN.
  assign run         = (state == ST_RUN) && rst_n;
  assign wr_go       = run && wea && ({1'b0, addra} < DEPTH_X);
  assign rd_go       = run && reb;
  assign rd_in_range = ({1'b0, addrb} < DEPTH_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_addr <= '0;
    end else if (state == ST_INIT) begin
      if (init_addr == LAST_ADDR) begin
        state     <= ST_RUN;
        init_addr <= '0;
      end else begin
        init_addr <= init_addr + 1'b1;
      end
    end
  end

  // The array has no reset. Only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT && rst_n) begin
      mem[init_addr] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NB; i++) begin
        if (bea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  // Reading the array here returns the pre-write word. WRITE_FIRST overlays
  // the bytes that are being written this cycle onto that word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[addrb];
      if (WR_FIRST && wr_go && (addra == addrb)) begin
        for (int i = 0; i < NB; i++) begin
          if (bea[i]) rd_word[8*i +: 8] = dina[8*i +: 8];
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0]   dat [READ_LATENCY];

  // A data stage loads only when its valid stage loads. This makes doutb
  // hold its last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) dat[k] <= '0;
    end else begin
      vld[0] <= rd_go;
      if (rd_go) dat[0] <= rd_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign doutb = dat[READ_LATENCY-1];
  assign dvalb = vld[READ_LATENCY-1];
  assign rdy   = run;

endmodule

// File: tb/tb_sram_sdp_pipe.sv
module tb_sram_sdp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wea, reb;
  logic [3:0]  bea;
  logic [3:0]  addra, addrb;
  logic [31:0] dina;
  logic [31:0] doutb_a, doutb_b;
  logic        dvalb_a, dvalb_b, rdy_a, rdy_b;

  always #5 clk = ~clk;

  // Instance a: DEPTH 16, latency 3, READ_FIRST
  sram_sdp_pipe #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(3),
                  .COLLISION("READ_FIRST"), .INIT_ON_RESET(1), .RAM_STYLE("block"))
  dut_a (.clk(clk), .rst_n(rst_n), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
         .reb(reb), .addrb(addrb), .doutb(doutb_a), .dvalb(dvalb_a), .rdy(rdy_a));

  // Instance b: DEPTH 10, latency 1, WRITE_FIRST
  sram_sdp_pipe #(.DATA_WIDTH(32), .DEPTH(10), .READ_LATENCY(1),
                  .COLLISION("WRITE_FIRST"), .INIT_ON_RESET(1), .RAM_STYLE("auto"))
  dut_b (.clk(clk), .rst_n(rst_n), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
         .reb(reb), .addrb(addrb), .doutb(doutb_b), .dvalb(dvalb_b), .rdy(rdy_b));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model for both instances
  int dep_m [2] = '{16, 10};
  int lat_m [2] = '{3, 1};
  bit wf_m  [2] = '{1'b0, 1'b1};

  typedef struct {
    int          d;
    int          due;
    logic [31:0] dat;
  } pend_t;

  pend_t       q[$];
  logic [31:0] mmem [2][16];
  int          init_left [2];
  logic        exp_v [2];
  logic [31:0] exp_d [2];
  logic        exp_rdy [2];
  int          cyc = 0;

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    pend_t       keep[$];
    logic [31:0] rd;
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int d = 0; d < 2; d++) begin
        init_left[d] = dep_m[d];
        exp_v[d]     = 1'b0;
        exp_d[d]     = 32'h0;
        exp_rdy[d]   = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (init_left[d] > 0) begin
          mmem[d][dep_m[d] - init_left[d]] = 32'h0;
          init_left[d]--;
        end else begin
          if (reb) begin
            rd = (int'(addrb) < dep_m[d]) ? mmem[d][addrb] : 32'h0;
            if (wf_m[d] && wea && addra == addrb && int'(addra) < dep_m[d])
              rd = apply_be(rd, dina, bea);
            q.push_back('{d, cyc + lat_m[d] - 1, rd});
          end
          if (wea && int'(addra) < dep_m[d])
            mmem[d][addra] = apply_be(mmem[d][addra], dina, bea);
        end
        exp_rdy[d] = (init_left[d] == 0);
        exp_v[d]   = 1'b0;
      end
      foreach (q[i]) begin
        if (q[i].due == cyc) begin
          exp_v[q[i].d] = 1'b1;
          exp_d[q[i].d] = q[i].dat;
        end else if (q[i].due > cyc) begin
          keep.push_back(q[i]);
        end
      end
      q = keep;
    end
  end

  // Compare process: every cycle, shortly after the rising edge
  always @(posedge clk) begin
    #1;
    chk("rdy_a",   32'(rdy_a),   32'(exp_rdy[0]));
    chk("dvalb_a", 32'(dvalb_a), 32'(exp_v[0]));
    chk("doutb_a", doutb_a,      exp_d[0]);
    chk("rdy_b",   32'(rdy_b),   32'(exp_rdy[1]));
    chk("dvalb_b", 32'(dvalb_b), 32'(exp_v[1]));
    chk("doutb_b", doutb_b,      exp_d[1]);
  end

  // Stimulus helpers; all inputs change on the falling edge
  task automatic drive(input logic we, input logic [3:0] be, input logic [3:0] aa,
                       input logic [31:0] d, input logic re, input logic [3:0] ab);
    @(negedge clk);
    wea = we; bea = be; addra = aa; dina = d; reb = re; addrb = ab;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  // Called right after the cycle that drove reb: checks b (latency 1) and a (latency 3)
  task automatic rd_tail(input string name, input logic [31:0] ea, input logic [31:0] eb);
    idle();
    chk({name, "_dval_b"}, 32'(dvalb_b), 32'h1);
    chk({name, "_dout_b"}, doutb_b, eb);
    idle();
    idle();
    chk({name, "_dval_a"}, 32'(dvalb_a), 32'h1);
    chk({name, "_dout_a"}, doutb_a, ea);
  endtask

  task automatic rd_lit(input string name, input logic [3:0] ad,
                        input logic [31:0] ea, input logic [31:0] eb);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ad);
    rd_tail(name, ea, eb);
  endtask

  task automatic wait_rdy(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int c = 0; c < 200; c++) begin
      if (rdy_a && rdy_b) break;
      if (!rdy_a) na++;
      if (!rdy_b) nb++;
      @(negedge clk);
    end
    chk("rdy_timeout", 32'(rdy_a && rdy_b), 32'h1);
  endtask

  initial begin
    int na, nb;
    wea = 1'b0; reb = 1'b0; bea = 4'h0; addra = 4'h0; addrb = 4'h0; dina = 32'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy_a",   32'(rdy_a),   32'h0);
    chk("reset_dvalb_a", 32'(dvalb_a), 32'h0);
    chk("reset_doutb_a", doutb_a,      32'h0);
    chk("reset_doutb_b", doutb_b,      32'h0);

    // Zero sweep length after release
    rst_n = 1'b1;
    wait_rdy(na, nb);
    chk("init_len_a", na, 32'd16);
    chk("init_len_b", nb, 32'd10);

    // Back-to-back reads of every address after the sweep
    for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
    repeat (3) idle();
    rd_lit("zero_0",  4'd0,  32'h0, 32'h0);
    rd_lit("zero_15", 4'd15, 32'h0, 32'h0);

    // Write then read one cycle later; exact latency on instance a
    drive(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'h0);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    idle();
    chk("lat_b_dval",  32'(dvalb_b), 32'h1);
    chk("lat_b_dout",  doutb_b, 32'hDEADBEEF);
    chk("lat_a_n0",    32'(dvalb_a), 32'h0);
    idle();
    chk("lat_a_n1",    32'(dvalb_a), 32'h0);
    idle();
    chk("lat_a_dval",  32'(dvalb_a), 32'h1);
    chk("lat_a_dout",  doutb_a, 32'hDEADBEEF);
    idle();
    chk("lat_a_pulse", 32'(dvalb_a), 32'h0);
    chk("lat_a_hold",  doutb_a, 32'hDEADBEEF);

    // Byte enables
    drive(1'b1, 4'hF,    4'd2, 32'h11223344, 1'b0, 4'h0);
    drive(1'b1, 4'b0101, 4'd2, 32'hAABBCCDD, 1'b0, 4'h0);
    rd_lit("byte_en", 4'd2, 32'h11BB33DD, 32'h11BB33DD);

    // Same-address collision
    drive(1'b1, 4'hF, 4'd7, 32'h1, 1'b0, 4'h0);
    drive(1'b1, 4'hF, 4'd7, 32'h2, 1'b1, 4'd7);
    rd_tail("collide", 32'h1, 32'h2);
    rd_lit("after_collide", 4'd7, 32'h2, 32'h2);

    // Out-of-range address for instance b (in range for a)
    drive(1'b1, 4'hF, 4'd12, 32'hCAFE0012, 1'b0, 4'h0);
    rd_lit("oor_12", 4'd12, 32'hCAFE0012, 32'h0);
    rd_lit("keep_5", 4'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));

    // Randomized traffic, with a bias toward same-address collisions
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15)));
    end

    // Fill with non-zero data so the next sweep is visible
    for (int i = 0; i < 16; i++) drive(1'b1, 4'hF, 4'(i), 32'hA5A50000 | 32'(i), 1'b0, 4'h0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
      if (i == 4) rst_n = 1'b0;
    end
    idle();
    chk("rst_mid_dvalb_a", 32'(dvalb_a), 32'h0);
    chk("rst_mid_dvalb_b", 32'(dvalb_b), 32'h0);
    chk("rst_mid_rdy_a",   32'(rdy_a),   32'h0);
    rst_n = 1'b1;
    wait_rdy(na, nb);
    chk("reinit_len_a", na, 32'd16);
    chk("reinit_len_b", nb, 32'd10);
    for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
    repeat (3) idle();
    rd_lit("reinit_3", 4'd3, 32'h0, 32'h0);
    rd_lit("reinit_9", 4'd9, 32'h0, 32'h0);
    repeat (4) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
